// File: rtl/ripple_word_sequencer_pkg.sv
// ripple_word_sequencer_pkg
//   Shared definitions for the nibble-serial add/subtract sequencer:
//   the adder slice width and the controller state encoding.
`timescale 1ns/1ps
package ripple_word_sequencer_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ripple_word_sequencer_adder.sv
// RippleAdder_4
//   Combinational 4-bit ripple-carry adder: {cout, sum} = a + b + cin.
//   Ports:
//     a, b  in  4  addends
//     cin   in  1  carry in
//     sum   out 4  sum
//     cout  out 1  carry out of bit 3
`timescale 1ns/1ps
module RippleAdder_4
    import ripple_word_sequencer_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < NIBBLE_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout = c[NIBBLE_W];
    end

endmodule

// File: rtl/ripple_word_sequencer.sv
// ripple_word_sequencer
//   Computes a WIDTH-bit add (a+b+cin) or subtract (a-b) with a single 4-bit
//   ripple adder, one nibble per clock, LS nibble first. The carry between
//   nibbles is held in a flop. Request side is valid/ready, result side is
//   valid/ready with the result held until taken.
//   Ports:
//     clk, rst            clock (rising edge), async active-high reset
//     in_valid/in_ready   request handshake; a, b, sub, cin sampled on accept
//     out_valid/out_ready result handshake
//     sum, cout, ovf      result, final carry (sub: 1 = no borrow), signed overflow
//     busy                high while an operation is running or awaiting pickup
`timescale 1ns/1ps
module ripple_word_sequencer
    import ripple_word_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);
    localparam int MSB = WIDTH - 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;         // b already inverted for subtract
    logic [WIDTH-1:0]   work_q, work_d;   // partial result, not visible outside
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] add_a, add_b, add_sum;
    logic                add_cout;

    assign add_a = a_q[NIBBLE_W*cnt_q +: NIBBLE_W];
    assign add_b = b_q[NIBBLE_W*cnt_q +: NIBBLE_W];

    RippleAdder_4 u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                work_d[NIBBLE_W*cnt_q +: NIBBLE_W] = add_sum;
                carry_d = add_cout;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    // Output register takes the completed word, including the
                    // nibble produced in this very pass, so sum never shows partials.
                    sum_d   = work_d;
                    cout_d  = add_cout;
                    ovf_d   = (a_q[MSB] == b_q[MSB]) & (add_sum[NIBBLE_W-1] != a_q[MSB]);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_ripple_word_sequencer.sv
`timescale 1ns/1ps
module tb_ripple_word_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #1 clk = ~clk;

    ripple_word_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    typedef struct {
        string        name;
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives a request at a negedge, returns the number of posedges from the
    // accept edge (inclusive) up to the first cycle out_valid is seen high.
    // Leaves the result pending in DONE with out_ready low.
    task automatic start_and_wait(input vec_t v, input bit pulse_in_run, output int lat);
        lat = 0;
        @(negedge clk);
        check({v.name, " in_ready idle"}, {31'd0, in_ready}, 32'd1);
        sub = v.sub; a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (pulse_in_run && n == 2) begin
                // competing request while running; must be ignored
                check({v.name, " in_ready in RUN"}, {31'd0, in_ready}, 32'd0);
                sub = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b1; in_valid = 1'b1;
            end
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        in_valid = 1'b0;
        check({v.name, " latency"}, lat, 32'd5);
    endtask

    task automatic check_result(input vec_t v);
        check({v.name, " sum"},  {16'd0, sum}, {16'd0, v.exp_sum});
        check({v.name, " cout"}, {31'd0, cout}, {31'd0, v.exp_cout});
        check({v.name, " ovf"},  {31'd0, ovf},  {31'd0, v.exp_ovf});
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        check({name, " in_ready in DONE"}, {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " out_valid dropped"}, {31'd0, out_valid}, 32'd0);
        check({name, " in_ready back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int   lat;
        vec_t v;

        vecs[0] = '{"add_basic",    1'b0, 16'h00FE, 16'h0A0E, 1'b1, 16'h0B0D, 1'b0, 1'b0};
        vecs[1] = '{"add_ripple",   1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{"sub_borrow",   1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{"sub_noborrow", 1'b1, 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, 1'b0};
        vecs[4] = '{"add_ovf",      1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{"sub_ovf",      1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{"add_negovf",   1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{"sub_cin_ign",  1'b1, 16'h0010, 16'h0010, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset in_ready",  {31'd0, in_ready},  32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset busy",      {31'd0, busy},      32'd0);
        check("reset sum",       {16'd0, sum},       32'd0);
        check("reset cout_ovf",  {30'd0, cout, ovf}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            start_and_wait(vecs[i], 1'b0, lat);
            check({vecs[i].name, " busy"}, {31'd0, busy}, 32'd1);
            check_result(vecs[i]);
            drain(vecs[i].name);
            // result stays on the outputs while idle
            check_result(vecs[i]);
        end

        // Back-pressure with a competing request pulsed during RUN
        v = '{"backpress", 1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        start_and_wait(v, 1'b1, lat);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("backpress out_valid held", {31'd0, out_valid}, 32'd1);
            check_result(v);
        end
        drain(v.name);
        repeat (3) @(negedge clk);
        check("no queued op", {30'd0, out_valid, busy}, 32'd0);

        // Reset during the second RUN cycle, observed before any clock edge
        @(negedge clk);
        sub = 1'b0; a = 16'h0F0F; b = 16'h0101; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);   // accepted; first RUN cycle
        in_valid = 1'b0;
        @(negedge clk);   // second RUN cycle
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #0.3;
        check("async rst out_valid", {31'd0, out_valid}, 32'd0);
        check("async rst in_ready",  {31'd0, in_ready},  32'd1);
        check("async rst busy",      {31'd0, busy},      32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("no result after rst", {31'd0, out_valid}, 32'd0);
        v = '{"post_rst", 1'b0, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0};
        start_and_wait(v, 1'b0, lat);
        check_result(v);
        drain(v.name);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
